// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request FSM feeding a prefetch
// queue, with a registered output stage toward decode.
module if_stage #(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         INS_W    = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              hold_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic [INS_W-1:0]  ins_o,
    output logic [ADDR_W-1:0] ins_addr_o,
    output logic              ins_valid_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fpc_q, fpc_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   q_addr_q [DEPTH];
    logic [ADDR_W-1:0]   q_addr_d [DEPTH];
    logic [INS_W-1:0]    q_ins_q  [DEPTH];
    logic [INS_W-1:0]    q_ins_d  [DEPTH];
    logic [INS_W-1:0]    ins_q, ins_d;
    logic [ADDR_W-1:0]   ins_addr_q, ins_addr_d;
    logic                ins_valid_q, ins_valid_d;

    logic                flush_c, push_c, pop_c;
    logic [ADDR_W-1:0]   target_c;

    assign flush_c  = clr | jump_en;
    assign target_c = clr ? RESET_PC : jump_addr;
    assign push_c   = (state_q == S_WAIT) && imem_ack && !flush_c;
    assign pop_c    = !flush_c && !hold_en && (count_q != '0);

    // Request FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Request FSM: next state; a flushed in-flight request must have its ack swallowed in DROP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!flush_c && (count_q < CNT_W'(DEPTH))) state_d = S_WAIT;
            S_WAIT: begin
                if (flush_c)       state_d = imem_ack ? S_IDLE : S_DROP;
                else if (imem_ack) state_d = (count_d < CNT_W'(DEPTH)) ? S_WAIT : S_IDLE;
            end
            S_DROP: if (imem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request FSM: outputs
    always_comb begin
        imem_req = 1'b0;
        if (state_q == S_WAIT) imem_req = 1'b1;
    end

    assign imem_addr = fpc_q;

    // Fetch PC, queue bookkeeping and output stage
    always_comb begin
        fpc_d       = fpc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        q_addr_d    = q_addr_q;
        q_ins_d     = q_ins_q;
        ins_d       = ins_q;
        ins_addr_d  = ins_addr_q;
        ins_valid_d = ins_valid_q;

        if (flush_c) begin
            fpc_d       = target_c;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            ins_d       = NOP;
            ins_addr_d  = '0;
            ins_valid_d = 1'b0;
        end else begin
            if (push_c) begin
                fpc_d              = fpc_q + ADDR_W'(4);
                q_addr_d[wr_ptr_q] = fpc_q;
                q_ins_d[wr_ptr_q]  = imem_rdata;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

            if (!hold_en) begin
                if (count_q != '0) begin
                    ins_d       = q_ins_q[rd_ptr_q];
                    ins_addr_d  = q_addr_q[rd_ptr_q];
                    ins_valid_d = 1'b1;
                end else begin
                    ins_d       = NOP;
                    ins_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q       <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ins_q       <= NOP;
            ins_addr_q  <= '0;
            ins_valid_q <= 1'b0;
        end else begin
            fpc_q       <= fpc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ins_q       <= ins_d;
            ins_addr_q  <= ins_addr_d;
            ins_valid_q <= ins_valid_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        q_addr_q <= q_addr_d;
        q_ins_q  <= q_ins_d;
    end

    assign ins_o       = ins_q;
    assign ins_addr_o  = ins_addr_q;
    assign ins_valid_o = ins_valid_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-002 SHALL have parameter INS_W, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset or clr.
REQ-004 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port clr  in  1  synchronous flush; restart fetch at RESET_PC.
REQ-008 SHALL have port jump_en  in  1  redirect request.
REQ-009 SHALL have port jump_addr  in  ADDR_W  redirect target.
REQ-010 SHALL have port hold_en  in  1  stall downstream output.
REQ-011 SHALL have port imem_req  out  1  fetch request valid.
REQ-012 SHALL have port imem_addr  out  ADDR_W  fetch address.
REQ-013 SHALL have port imem_ack  in  1  fetch data valid, one cycle per request.
REQ-014 SHALL have port imem_rdata  in  INS_W  fetched word, valid with imem_ack.
REQ-015 SHALL have port ins_o  out  INS_W  registered instruction to decode.
REQ-016 SHALL have port ins_addr_o  out  ADDR_W  registered address of ins_o.
REQ-017 SHALL have port ins_valid_o  out  1  ins_o is a real fetched instruction.

Function
REQ-018 SHALL keep fetch PC register fpc; imem_addr = fpc combinationally.
REQ-019 SHALL run request FSM with states IDLE, WAIT, DROP.
REQ-020 IDLE -> WAIT when queue count + 1 <= DEPTH (space exists) and no jump_en/clr this cycle; imem_req = 1 only in WAIT.
REQ-021 WAIT: imem_req and imem_addr held stable until imem_ack; on ack push {fpc, imem_rdata}, fpc <= fpc + 4 (mod 2^ADDR_W), go to WAIT again if space remains after push, else IDLE.
REQ-022 At most one outstanding request at any time; ack in the request cycle is legal (zero-wait memory gives one word per cycle).
REQ-023 jump_en or clr in WAIT without imem_ack -> DROP; fpc <= target; next ack SHALL be discarded, then DROP -> IDLE.
REQ-024 jump_en or clr in WAIT with imem_ack -> word discarded, fpc <= target, state IDLE.
REQ-025 jump_en or clr in IDLE or DROP: fpc <= target; DROP remains DROP until ack.
REQ-026 Target = RESET_PC for clr, jump_addr for jump_en; clr wins if both asserted.
REQ-027 jump_en/clr SHALL empty the queue and set ins_valid_o <= 0, ins_o <= 32'h00000013 (NOP), ins_addr_o <= 0, regardless of hold_en.
REQ-028 Output stage, no flush: hold_en = 1 -> ins_o, ins_addr_o, ins_valid_o unchanged, no pop.
REQ-029 hold_en = 0 and queue non-empty -> head loaded to ins_o/ins_addr_o, ins_valid_o <= 1, pop.
REQ-030 hold_en = 0 and queue empty -> ins_valid_o <= 0, ins_o <= NOP, ins_addr_o unchanged.
REQ-031 Simultaneous push and pop SHALL leave count unchanged; full queue never accepts push (guaranteed by REQ-020); pointers wrap modulo DEPTH.
REQ-032 Queue is not bypassed: earliest ins_valid_o is two cycles after the ack cycle... specifically ack at edge N pushes, pop at edge N+1 drives outputs.
REQ-033 Instructions SHALL leave in fetch order with no loss or duplication outside flushes.

Reset
REQ-034 rst = 1 SHALL immediately force fpc = RESET_PC, state IDLE, queue empty, ins_o = NOP, ins_addr_o = 0, ins_valid_o = 0, imem_req = 0.
REQ-035 Reset during WAIT SHALL drop the outstanding request; an imem_ack arriving after rst release SHALL be ignored only if in DROP, so the memory model must also be reset by rst.
REQ-036 First request SHALL be issued the first cycle after rst deassertion.

Verification
REQ-037 Reset release, zero-wait memory returning addr as data, hold_en = 0 -> ins_addr_o sequence 0,4,8,12 with ins_valid_o = 1 every cycle after startup.
REQ-038 Memory with 3-cycle ack latency -> imem_addr stable during wait, ins_valid_o pulses once per 3-4 cycles, no duplicate addresses.
REQ-039 hold_en = 1 for 10 cycles, DEPTH = 4 -> queue fills to 4, imem_req drops, outputs frozen; release -> 4 queued words emitted back-to-back, then fetch resumes at 0x10 beyond last queued.
REQ-040 jump_en with jump_addr = 0x100 while request to 0x8 pending -> late ack for 0x8 discarded, next ins_addr_o valid = 0x100, NOP with valid = 0 in between.
REQ-041 clr and jump_en together with hold_en = 1 -> outputs flushed to NOP, fetch restarts at RESET_PC.
REQ-042 rst asserted mid-WAIT with queue half full -> all outputs at reset values asynchronously, first post-reset request addr = RESET_PC.
